prio_enc_seg_scan: RTL and testbench

Parametrised, registered priority encoder with a time-multiplexed multi-digit seven-segment display.
- Encodes an N_IN-bit request vector to the index of its highest set bit, with a valid flag and a freeze (hold) mode.
- Scans the encoded index out in hex across DIGITS common-anode digits.
- Sits between board switch/button inputs and the seven-segment/anode pins; this is the next generation of the 8-to-3 encoder plus single-digit decoder.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/hex7seg.sv | 16 +
 rtl/prio_enc_seg_scan.sv | 126 ++++++++++++
 tb/tb_prio_enc_seg_scan.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Seven-segment helpers shared by the display path.
// SEG_HEX holds the a..g patterns (1 = lit) for hex digits 0..F.
// hex2seg turns a nibble plus a blank flag into the active-low pin byte
// {a,b,c,d,e,f,g,dp}, with the decimal point always off.
package seg_pkg;

  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] hex2seg(input logic [3:0] nib, input logic blank);
    if (blank) return SEG_BLANK;
    // Pattern bits are active-high, the pins are active-low; dp slot stays 0 before inversion.
    return ~{SEG_HEX[nib], 1'b0};
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to seven-segment decoder.
// Ports:
//   nib   - hex digit to display
//   blank - 1 forces all segments off
//   seg   - active-low segments, seg[7:1] = a..g, seg[0] = dp (always off)
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [7:0] seg
);

  assign seg = hex2seg(nib, blank);

endmodule

// File: rtl/prio_enc_seg_scan.sv
// Registered priority encoder driving a time-multiplexed hex display.
// The encoder stores the index of the highest set request bit; the index
// is shown in hex across DIGITS common-anode digits, one digit enabled at
// a time for SCAN_DIV clocks each.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   en    - encoder enable (clears the result when low and not holding)
//   hold  - freeze idx/valid; takes priority over en
//   x     - request vector
//   idx   - registered index of the highest set bit of x
//   valid - registered flag, some bit of x was set while enabled
//   seg   - active-low segments {a..g, dp}; blank while valid is low
//   an    - active-low one-hot digit enables
module prio_enc_seg_scan
  import seg_pkg::*;
#(
  parameter  int N_IN     = 16,
  parameter  int DIGITS   = 2,
  parameter  int SCAN_DIV = 50000,
  localparam int W        = $clog2(N_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              hold,
  input  logic [N_IN-1:0]   x,
  output logic [W-1:0]      idx,
  output logic              valid,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = DIGITS * 4;
  localparam logic [DIGITS-1:0] AN_RST = ~DIGITS'(1);

  generate
    if (DIGITS * 4 < W) begin : g_width_chk
      $error("DIGITS*4 must be at least the index width");
    end
  endgenerate

  function automatic logic [W-1:0] msb_idx(input logic [N_IN-1:0] v);
    logic [W-1:0] r;
    r = '0;
    // Ascending scan, so the last hit (highest bit) wins.
    for (int i = 0; i < N_IN; i++) begin
      if (v[i]) r = W'(i);
    end
    return r;
  endfunction

  logic [W-1:0]      idx_p0;
  logic              vld_p0;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     ptr;
  logic              wrap;
  logic [DW-1:0]     disp;
  logic [3:0]        nib;
  logic [7:0]        seg_nxt;
  logic [DIGITS-1:0] an_nxt;
  logic [7:0]        seg_p1;
  logic [DIGITS-1:0] an_p1;

  // ---- stage p0: encoder register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_p0 <= '0;
      vld_p0 <= 1'b0;
    end else if (!hold) begin
      if (en) begin
        idx_p0 <= msb_idx(x);
        vld_p0 <= |x;
      end else begin
        idx_p0 <= '0;
        vld_p0 <= 1'b0;
      end
    end
  end

  // Scan counter and digit pointer run independently of en/hold.
  assign wrap = (cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ptr <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) ptr <= (ptr == PW'(DIGITS - 1)) ? '0 : ptr + 1'b1;
    end
  end

  always_comb begin
    disp         = '0;
    disp[W-1:0]  = idx_p0;
    nib          = disp[int'(ptr)*4 +: 4];
    an_nxt       = '1;
    an_nxt[ptr]  = 1'b0;
  end

  hex7seg u_hex7seg (
    .nib   (nib),
    .blank (~vld_p0),
    .seg   (seg_nxt)
  );

  // ---- stage p1: pin registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_p1 <= SEG_BLANK;
      an_p1  <= AN_RST;
    end else begin
      seg_p1 <= seg_nxt;
      an_p1  <= an_nxt;
    end
  end

  assign idx   = idx_p0;
  assign valid = vld_p0;
  assign seg   = seg_p1;
  assign an    = an_p1;

endmodule

// File: tb/tb_prio_enc_seg_scan.sv
module tb_prio_enc_seg_scan;

  localparam int N_IN     = 16;
  localparam int DIGITS   = 2;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        hold;
  logic [15:0] x;
  logic [3:0]  idx;
  logic        valid;
  logic [7:0]  seg;
  logic [1:0]  an;

  prio_enc_seg_scan #(
    .N_IN     (N_IN),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .hold  (hold),
    .x     (x),
    .idx   (idx),
    .valid (valid),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] idx;
    logic       valid;
    logic [7:0] seg;
    logic [1:0] an;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: encoder result and number of clock edges since reset.
  int   m_idx;
  bit   m_vld;
  int   k;

  logic [6:0] hex_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: apply inputs for the next rising edge,
  // queue the outputs expected after it, then move to the next falling edge.
  task automatic step(input bit e, input bit h, input logic [15:0] xv);
    exp_t t;
    int   p;
    int   nib;
    en = e; hold = h; x = xv;
    // Digit slot selected during the cycle before the edge.
    p    = (k / SCAN_DIV) % DIGITS;
    t.an = 2'b11;
    t.an[p] = 1'b0;
    nib   = (m_idx >> (4 * p)) & 15;
    t.seg = m_vld ? ~{hex_tab[nib], 1'b0} : 8'hFF;
    if (!h) begin
      m_idx = 0;
      m_vld = 0;
      if (e) begin
        for (int i = 15; i >= 0; i--) begin
          if (xv[i]) begin
            m_idx = i;
            m_vld = 1;
            break;
          end
        end
      end
    end
    t.idx   = 4'(m_idx);
    t.valid = m_vld;
    k++;
    q.push_back(t);
    @(negedge clk);
  endtask

  // Called at a falling edge; asserts reset between edges and releases it at a falling edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_idx", 32'(idx), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_an", 32'(an), 32'h2);
    chk("rst_seg", 32'(seg), 32'hFF);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_idx", 32'(idx), 32'h0);
      chk("rst_hold_valid", 32'(valid), 32'h0);
      chk("rst_hold_an", 32'(an), 32'h2);
      chk("rst_hold_seg", 32'(seg), 32'hFF);
    end
    rst   = 1'b0;
    m_idx = 0;
    m_vld = 0;
    k     = 0;
    q.delete();
  endtask

  always begin : monitor
    exp_t t;
    @(posedge clk);
    #1;
    if (!rst && q.size() > 0) begin
      t = q.pop_front();
      chk("idx", 32'(idx), 32'(t.idx));
      chk("valid", 32'(valid), 32'(t.valid));
      chk("seg", 32'(seg), 32'(t.seg));
      chk("an", 32'(an), 32'(t.an));
      chk("an_onehot", 32'($countones(~an)), 32'd1);
    end
  end

  function automatic logic [15:0] rand_x();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'h0001 << $urandom_range(0, 15);
      2:       return 16'($urandom);
      default: return 16'($urandom & $urandom & $urandom);
    endcase
  endfunction

  initial begin
    int guard;
    rst = 1'b1; en = 1'b0; hold = 1'b0; x = '0;
    m_idx = 0; m_vld = 0; k = 0;
    @(negedge clk);
    do_reset();

    // Idle with encoder off: scan runs, display blank.
    repeat (6) step(0, 0, 16'h0000);

    // Request 0x0891 -> index 0xB on digit 0, "0" on digit 1.
    repeat (10) step(1, 0, 16'h0891);

    // Empty request, then disabled with everything set.
    repeat (8) step(1, 0, 16'h0000);
    repeat (3) step(0, 0, 16'hFFFF);

    // Hold keeps 0xB against a new request, release picks up 0xF, hold beats en=0.
    repeat (2) step(1, 0, 16'h0891);
    repeat (10) step(1, 1, 16'h8000);
    step(1, 0, 16'h8000);
    repeat (4) step(0, 1, 16'h0000);

    // Edge inputs: lowest bit shows a real "0", highest bit gives 0xF.
    repeat (9) step(1, 0, 16'h0001);
    repeat (5) step(1, 0, 16'h8000);
    // Reset mid-dwell and mid-hold discards the frozen value.
    step(1, 1, 16'h0000);
    do_reset();
    repeat (10) step(0, 0, 16'h0000);

    // Randomised traffic with an occasional reset.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0, rand_x());
      if (n == 200) do_reset();
    end

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
